// File: rtl/md_pkg.sv
// md_pkg -- shared definitions for the multiply/divide unit.
//   md_op encodings, FSM state type, and op-class helpers.
//   Optional feature macro: MD_MADD_EN (madd/maddu/msub/msubu are multicycle).
package md_pkg;

  localparam int MD_OP_W = 4;

  typedef enum logic [3:0] {
    MD_MULT  = 4'd0,
    MD_MULTU = 4'd1,
    MD_DIV   = 4'd2,
    MD_DIVU  = 4'd3,
    MD_MTHI  = 4'd4,
    MD_MTLO  = 4'd5,
    MD_MFHI  = 4'd6,
    MD_MFLO  = 4'd7,
    MD_MADD  = 4'd8,
    MD_MADDU = 4'd9,
    MD_MSUB  = 4'd10,
    MD_MSUBU = 4'd11
  } md_op_e;

  typedef enum logic {IDLE, RUN} md_state_e;

  function automatic logic is_div(logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_acc(logic [3:0] op);
`ifdef MD_MADD_EN
    return (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
`else
    return (op != op);
`endif
  endfunction

  function automatic logic is_multicycle(logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || is_div(op) || is_acc(op);
  endfunction

endpackage

// File: rtl/md_calc.sv
// md_calc -- combinational 2*DATA_W result generator.
//   op   : md_op code
//   a, b : operands (rs, rt)
//   res  : {hi, lo} result (product, or {remainder, quotient})
//   keep : divide by zero, HI/LO must stay unchanged at commit
// Optional feature macro: MD_MADD_EN (madd group yields the product).
module md_calc
  import md_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]          op,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic [2*DATA_W-1:0] res,
  output logic                keep
);

  logic [2*DATA_W-1:0] prod_s, prod_u;
  logic [DATA_W-1:0]   ua, ub, dv, q, r, sq, sr;
  logic                neg_a, neg_b, sdiv;

  // Sign-extending to 2*DATA_W before an unsigned multiply gives the
  // correct two's-complement product in the low 2*DATA_W bits.
  assign prod_u = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
  assign prod_s = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{b[DATA_W-1]}}, b};

  // Signed divide on magnitudes. most-negative / -1 falls out naturally:
  // |MIN| / 1 = MIN pattern, negated stays MIN, remainder 0.
  assign sdiv  = (op == MD_DIV);
  assign neg_a = sdiv & a[DATA_W-1];
  assign neg_b = sdiv & b[DATA_W-1];
  assign ua    = neg_a ? -a : a;
  assign ub    = neg_b ? -b : b;
  assign dv    = (ub == '0) ? DATA_W'(1) : ub;  // keeps the divider defined on /0
  assign q     = ua / dv;
  assign r     = ua % dv;
  assign sq    = (neg_a ^ neg_b) ? -q : q;
  assign sr    = neg_a ? -r : r;

  always_comb begin
    res  = '0;
    keep = 1'b0;
    case (op)
      MD_MULT:  res = prod_s;
      MD_MULTU: res = prod_u;
      MD_DIV, MD_DIVU: begin
        res  = {sr, sq};
        keep = (b == '0);
      end
`ifdef MD_MADD_EN
      MD_MADD, MD_MSUB:   res = prod_s;
      MD_MADDU, MD_MSUBU: res = prod_u;
`endif
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// md_unit -- E-stage multiply/divide unit owning HI/LO.
//   clk, reset     : clock, synchronous active-high reset
//   start, md_op   : md-class instruction valid in E, and its op code
//   src_a, src_b   : forwarded rs / rt
//   busy           : multicycle op in flight
//   hazard         : busy | (start & multicycle op), combinational to stall unit
//   hi, lo         : architectural HI / LO
// Optional feature macro: MD_MADD_EN (madd/maddu/msub/msubu accumulate into HI/LO).
module md_unit
  import md_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        md_op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic              busy,
  output logic              hazard,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int MAX_CYC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  md_state_e           state;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   shadow_hi, shadow_lo;
  logic                keep_q;
  logic [2*DATA_W-1:0] calc_res, commit_val;
  logic                calc_keep;

  md_calc #(.DATA_W(DATA_W)) u_calc (
    .op   (md_op),
    .a    (src_a),
    .b    (src_b),
    .res  (calc_res),
    .keep (calc_keep)
  );

  assign hazard = busy | (start & is_multicycle(md_op));

`ifdef MD_MADD_EN
  logic acc_q, sub_q;
  // Accumulate uses HI/LO as they stand at commit, not at start.
  always_comb begin
    commit_val = {shadow_hi, shadow_lo};
    if (acc_q)
      commit_val = sub_q ? ({hi, lo} - {shadow_hi, shadow_lo})
                         : ({hi, lo} + {shadow_hi, shadow_lo});
  end
`else
  assign commit_val = {shadow_hi, shadow_lo};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      cnt       <= '0;
      shadow_hi <= '0;
      shadow_lo <= '0;
      keep_q    <= 1'b0;
      hi        <= '0;
      lo        <= '0;
`ifdef MD_MADD_EN
      acc_q     <= 1'b0;
      sub_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (is_multicycle(md_op)) begin
              state                  <= RUN;
              busy                   <= 1'b1;
              cnt                    <= is_div(md_op) ? CNT_W'(DIV_CYCLES - 1)
                                                      : CNT_W'(MULT_CYCLES - 1);
              {shadow_hi, shadow_lo} <= calc_res;
              keep_q                 <= calc_keep;
`ifdef MD_MADD_EN
              acc_q                  <= is_acc(md_op);
              sub_q                  <= (md_op == MD_MSUB) || (md_op == MD_MSUBU);
`endif
            end else if (md_op == MD_MTHI) begin
              hi <= src_a;
            end else if (md_op == MD_MTLO) begin
              lo <= src_a;
            end
          end
        end
        RUN: begin
          // start is ignored here, including on the commit cycle.
          if (cnt == '0) begin
            if (!keep_q) {hi, lo} <= commit_val;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit -- directed, table-driven bench for md_unit plus hand-written
// sequences for start-while-busy, commit/start collision and mid-op reset.
module tb_md_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] src_a, src_b;
  logic        busy, hazard;
  logic [31:0] hi, lo;

  int n_chk  = 0;
  int n_fail = 0;

  md_unit #(.DATA_W(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .src_a(src_a), .src_b(src_b), .busy(busy), .hazard(hazard),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [31:0] ehi, elo;
    int          ecyc;
  } vec_t;

  vec_t vt[15];

  function automatic vec_t mk(string n, logic [3:0] op, logic [31:0] a, logic [31:0] b,
                              logic [31:0] ehi, logic [31:0] elo, int ecyc);
    vec_t v;
    v.name = n; v.op = op; v.a = a; v.b = b; v.ehi = ehi; v.elo = elo; v.ecyc = ecyc;
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Issue one op at a negedge, then count busy cycles (bounded).
  task automatic do_op(string nm, logic [3:0] op, logic [31:0] a, logic [31:0] b,
                       int ecyc, output int cyc);
    @(negedge clk);
    start = 1'b1; md_op = op; src_a = a; src_b = b;
    #1 chk({nm, " hazard"}, 64'(hazard), 64'(ecyc != 0));
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  initial begin
    int cyc;
    logic [31:0] madd_lo, madd_cyc;
`ifdef MD_MADD_EN
    madd_lo = 32'd22; madd_cyc = 32'd5;
`else
    madd_lo = 32'd10; madd_cyc = 32'd0;
`endif
    vt[0]  = mk("mult -2*3",      MD_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5);
    vt[1]  = mk("divu 100/7",     MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       10);
    vt[2]  = mk("div -7/2",       MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    vt[3]  = mk("mthi",           MD_MTHI,  32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFD, 0);
    vt[4]  = mk("mtlo",           MD_MTLO,  32'h9ABCDEF0, 32'd0,        32'h12345678, 32'h9ABCDEF0, 0);
    vt[5]  = mk("div by zero",    MD_DIV,   32'd5,        32'd0,        32'h12345678, 32'h9ABCDEF0, 10);
    vt[6]  = mk("mfhi",           MD_MFHI,  32'hDEAD,     32'hBEEF,     32'h12345678, 32'h9ABCDEF0, 0);
    vt[7]  = mk("multu max*max",  MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5);
    vt[8]  = mk("div overflow",   MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 10);
    vt[9]  = mk("div 7/-2",       MD_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 10);
    vt[10] = mk("divu big/16",    MD_DIVU,  32'hFFFFFFFF, 32'h10,       32'hF,        32'h0FFFFFFF, 10);
    vt[11] = mk("mthi 0",         MD_MTHI,  32'h0,        32'd0,        32'h0,        32'h0FFFFFFF, 0);
    vt[12] = mk("mtlo 10",        MD_MTLO,  32'd10,       32'd0,        32'h0,        32'd10,       0);
    vt[13] = mk("madd 3*4",       MD_MADD,  32'd3,        32'd4,        32'h0,        madd_lo,      int'(madd_cyc));
    vt[14] = mk("unknown op",     4'd15,    32'd1,        32'd1,        32'h0,        madd_lo,      0);

    reset = 1'b1; start = 1'b0; md_op = '0; src_a = '0; src_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset hi", 64'(hi), 64'h0);
    chk("reset lo", 64'(lo), 64'h0);
    chk("reset busy", 64'(busy), 64'h0);
    chk("reset hazard", 64'(hazard), 64'h0);

    foreach (vt[i]) begin
      do_op(vt[i].name, vt[i].op, vt[i].a, vt[i].b, vt[i].ecyc, cyc);
      chk({vt[i].name, " busy cycles"}, 64'(cyc), 64'(vt[i].ecyc));
      chk({vt[i].name, " hi"}, 64'(hi), 64'(vt[i].ehi));
      chk({vt[i].name, " lo"}, 64'(lo), 64'(vt[i].elo));
    end

    // start pulses while a divu runs, including on the commit cycle.
    @(negedge clk);
    start = 1'b1; md_op = MD_DIVU; src_a = 32'd100; src_b = 32'd7;
    @(negedge clk);
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      start = 1'b1; md_op = MD_MULT; src_a = 32'd5; src_b = 32'd5;
      $display("note: start asserted while busy (protocol error) cycle %0d", cyc);
      #1 chk("hazard while busy", 64'(hazard), 64'h1);
      @(negedge clk);
    end
    start = 1'b0;
    chk("busy cycles with stray start", 64'(cyc), 64'd10);
    chk("stray start not accepted", 64'(busy), 64'h0);
    chk("divu commit hi", 64'(hi), 64'd2);
    chk("divu commit lo", 64'(lo), 64'd14);
    @(negedge clk);
    chk("still idle after collision", 64'(busy), 64'h0);

    // Reset on cycle 3 of a mult aborts it.
    @(negedge clk);
    start = 1'b1; md_op = MD_MULT; src_a = 32'd6; src_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort busy", 64'(busy), 64'h0);
    chk("abort hi", 64'(hi), 64'h0);
    chk("abort lo", 64'(lo), 64'h0);
    repeat (8) @(negedge clk);
    chk("no late commit hi", 64'(hi), 64'h0);
    chk("no late commit lo", 64'(lo), 64'h0);
    chk("no late busy", 64'(busy), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
